// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: FSM states, access widths, ALU op codes
// and the alignment/reserved-width check applied when a memory op is accepted.
package lsu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_OR    = 4'd1,
        ALU_AND   = 4'd2,
        ALU_SLL   = 4'd3,
        ALU_PASSB = 4'd15
    } alu_op_t;

    // True when a memory op must be rejected without touching memory.
    function automatic logic access_err(input logic [2:0] f3, input logic [1:0] a);
        case (f3)
            F3_B, F3_BU: access_err = 1'b0;
            F3_H, F3_HU: access_err = a[0];
            F3_W:        access_err = (a != 2'b00);
            default:     access_err = 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/lsu_lane.sv
// Byte-lane logic: store byte enables and lane replication, load lane extraction
// with sign or zero extension.
module lsu_lane
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic        is_load,
    input  logic [31:0] st_data,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] ld_data
);

    logic [31:0] sh_word;
    logic [7:0]  b;
    logic [15:0] h;

    assign sh_word = rdata >> {addr_lo, 3'b000};
    assign b       = sh_word[7:0];
    assign h       = addr_lo[1] ? rdata[31:16] : rdata[15:0];

    always_comb begin
        be      = 4'b1111;
        wdata   = st_data;
        ld_data = rdata;
        case (funct3)
            F3_B, F3_BU: begin
                be      = 4'b0001 << addr_lo;
                wdata   = {4{st_data[7:0]}};
                ld_data = (funct3 == F3_B) ? {{24{b[7]}}, b} : {24'h0, b};
            end
            F3_H, F3_HU: begin
                be      = 4'b0011 << addr_lo;
                wdata   = {2{st_data[15:0]}};
                ld_data = (funct3 == F3_H) ? {{16{h[15]}}, h} : {16'h0, h};
            end
            default: ;
        endcase
        if (is_load)
            be = 4'b1111;
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit: accepts one execute result, performs at most one memory
// access (with bounded wait for read data) and presents the result downstream.
module lsu
    import lsu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] alu_y,
    input  logic [31:0] st_data,
    input  logic [2:0]  funct3,
    input  logic        mem_rd,
    input  logic        mem_wr,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        out_err
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    state_t      state;
    logic [2:0]  f3_q;
    logic [31:0] addr_q;
    logic [31:0] st_q;
    logic        is_load_q;
    logic [CW-1:0] cnt;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] ld_data;

    lsu_lane u_lane (
        .funct3  (f3_q),
        .addr_lo (addr_q[1:0]),
        .is_load (is_load_q),
        .st_data (st_q),
        .rdata   (mem_rdata),
        .be      (be),
        .wdata   (wdata),
        .ld_data (ld_data)
    );

    assign in_ready  = (state == ST_IDLE);
    assign mem_addr  = {addr_q[31:2], 2'b00};
    assign mem_be    = mem_req ? be : 4'b0000;
    assign mem_wdata = wdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            f3_q      <= 3'b000;
            addr_q    <= 32'h0;
            st_q      <= 32'h0;
            is_load_q <= 1'b0;
            cnt       <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= 32'h0;
            out_err   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: if (in_valid) begin
                    addr_q    <= alu_y;
                    st_q      <= st_data;
                    f3_q      <= funct3;
                    is_load_q <= mem_rd;
                    if (!mem_rd && !mem_wr) begin
                        state     <= ST_RESP;
                        out_valid <= 1'b1;
                        out_data  <= alu_y;
                        out_err   <= 1'b0;
                    end else if (access_err(funct3, alu_y[1:0])) begin
                        state     <= ST_RESP;
                        out_valid <= 1'b1;
                        out_data  <= 32'h0;
                        out_err   <= 1'b1;
                    end else begin
                        state   <= ST_REQ;
                        mem_req <= 1'b1;
                        mem_we  <= !mem_rd;
                    end
                end
                ST_REQ: if (mem_gnt) begin
                    mem_req <= 1'b0;
                    mem_we  <= 1'b0;
                    if (!is_load_q) begin
                        state     <= ST_RESP;
                        out_valid <= 1'b1;
                        out_data  <= addr_q;
                        out_err   <= 1'b0;
                    end else if (mem_rvalid) begin
                        state     <= ST_RESP;
                        out_valid <= 1'b1;
                        out_data  <= ld_data;
                        out_err   <= 1'b0;
                    end else begin
                        state <= ST_WAIT;
                        cnt   <= '0;
                    end
                end
                ST_WAIT: begin
                    if (mem_rvalid) begin
                        state     <= ST_RESP;
                        out_valid <= 1'b1;
                        out_data  <= ld_data;
                        out_err   <= 1'b0;
                    end else if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
                        state     <= ST_RESP;
                        out_valid <= 1'b1;
                        out_data  <= 32'h0;
                        out_err   <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_RESP: if (out_ready) begin
                    state     <= ST_IDLE;
                    out_valid <= 1'b0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/lsu.md
LSU -- requirements
Module: lsu

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 255, max cycles in WAIT before error.
REQ-002 clk  input  1  rising-edge clock; the only clock.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 in_valid  input  1  upstream holds a valid execute result.
REQ-005 in_ready  output  1  lsu accepts a transaction this cycle.
REQ-006 alu_y  input  32  ALU result, which is the effective address for memory ops.
REQ-007 st_data  input  32  rs2 value for stores.
REQ-008 funct3  input  3  width/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-009 mem_rd, mem_wr  input  1 each  load / store select; both low = pass-through.
REQ-010 mem_req, mem_we  output  1 each  memory request / write enable.
REQ-011 mem_addr  output  32  word-aligned address, alu_y with [1:0] forced to 00.
REQ-012 mem_be  output  4  byte enables; mem_wdata  output  32  lane-replicated store data.
REQ-013 mem_gnt, mem_rvalid  input  1 each  request accepted / read data valid.
REQ-014 mem_rdata  input  32  read word.
REQ-015 out_valid  output  1; out_ready  input  1; out_data  output  32; out_err  output  1.

Function
REQ-016 FSM states: IDLE, REQ, WAIT, RESP.
REQ-017 in_ready = 1 only in IDLE; a transaction is accepted on in_valid & in_ready.
REQ-018 On accept, inputs are registered and are never re-sampled until the next accept.
REQ-019 Pass-through op (mem_rd = mem_wr = 0): IDLE->RESP, out_data = alu_y, out_err = 0, latency 1 cycle.
REQ-020 mem_rd & mem_wr both high: treated as a load.
REQ-021 Misalignment: H/HU with alu_y[0] = 1, or W with alu_y[1:0] != 0, skips memory; IDLE->RESP with out_err = 1 and out_data = 0.
REQ-022 Aligned memory op: IDLE->REQ; mem_req is held high with stable mem_addr/mem_we/mem_be/mem_wdata until mem_gnt.
REQ-023 Store on mem_gnt: REQ->RESP, out_data = alu_y, out_err = 0.
REQ-024 Load on mem_gnt: REQ->WAIT, and the cycle counter clears.
REQ-025 WAIT: on mem_rvalid, WAIT->RESP with out_data = extracted lane.
REQ-026 Lane extraction: B/H sign-extend, BU/HU zero-extend, W is raw.
REQ-027 mem_rvalid in the same cycle as mem_gnt: REQ->RESP directly with data captured.
REQ-028 WAIT timeout: counter reaching TIMEOUT_CYCLES without mem_rvalid -> RESP, out_err = 1, out_data = 0; a late mem_rvalid is ignored.
REQ-029 Byte enables: B = 0001<<a[1:0]; H = 0011<<a[1:0]; W = 1111; loads use 1111.
REQ-030 mem_wdata: B = {4{st_data[7:0]}}; H = {2{st_data[15:0]}}; W = st_data.
REQ-031 RESP: out_valid = 1 and out_data/out_err stay stable until out_ready; then RESP->IDLE.
REQ-032 Back-to-back throughput is one transaction per 2 cycles minimum for pass-through (no IDLE bypass).
REQ-033 Reserved funct3 (011, 110, 111) on a memory op: out_err = 1 with no memory access.

Reset
REQ-034 rst_n low asynchronously forces IDLE.
REQ-035 Reset values: mem_req = 0, mem_we = 0, mem_be = 0, out_valid = 0, out_err = 0, out_data = 0, counter = 0.
REQ-036 Reset mid-REQ/WAIT drops the transaction silently; any later mem_rvalid is ignored.

Structure
REQ-037 Shared package holds: FSM state encoding, funct3 width codes, and the ALU op codes (ADD 0, OR 1, AND 2, SLL 3, PASSB 15).
REQ-038 One combinational sub-module, lsu_lane, performs byte-enable/wdata generation and load extraction/extension.

Verification
REQ-039 Pass-through: alu_y = 0x1234 with no mem op -> out_valid next cycle, out_data = 0x1234, out_err = 0.
REQ-040 SB: alu_y = 0x103, st_data = 0xAB -> mem_addr = 0x100, mem_be = 1000, mem_wdata = 0xABABABAB, mem_we = 1.
REQ-041 LB: alu_y = 0x102, mem_rdata = 0x00800000 -> out_data = 0xFFFFFF80; same with LBU -> 0x00000080.
REQ-042 LW: alu_y = 0x102 -> no mem_req, out_err = 1, out_data = 0.
REQ-043 Load with mem_gnt delayed 3 cycles and no rvalid -> timeout after 255 WAIT cycles, out_err = 1.
REQ-044 rst_n asserted while in WAIT, then rvalid pulsed -> out_valid stays 0 and in_ready = 1.
